// File: rtl/alarm_clock_fsm_pkg.sv
// Shared definitions for the alarm clock mode controller: key codes, timeout and state encodings.
package alarm_clock_fsm_pkg;

    localparam logic [3:0] NOKEY_CODE       = 4'hA;
    localparam int         TIMEOUT_SEC_DFLT = 10;

    typedef enum logic [2:0] {
        SHOW_TIME        = 3'd0,
        KEY_STORED       = 3'd1,
        KEY_WAITED       = 3'd2,
        KEY_ENTRY        = 3'd3,
        SHOW_ALARM       = 3'd4,
        SET_ALARM_TIME   = 3'd5,
        SET_CURRENT_TIME = 3'd6
    } state_t;

    function automatic logic key_pressed(input logic [3:0] key, input logic [3:0] nokey);
        return (key != nokey);
    endfunction

endpackage

// File: rtl/alarm_clock_fsm_timer.sv
// Inactivity timer for key entry: counts one_second pulses while enabled and flags the final one.
module key_timeout_timer #(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic one_second,
    output logic timeout
);

    localparam int               TW    = $clog2(TIMEOUT_SEC + 1);
    localparam logic [TW-1:0]    TMAX  = TW'(TIMEOUT_SEC);
    localparam logic [TW-1:0]    TLAST = TW'(TIMEOUT_SEC - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // Next timer value: clear wins, otherwise count seconds up to a saturating ceiling.
    always_comb begin
        timer_d = timer_q;
        if (clear) begin
            timer_d = '0;
        end else if (enable && one_second && (timer_q != TMAX)) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    // Timer register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timeout = enable && one_second && (timer_q == TLAST);

endmodule

// File: rtl/alarm_clock_fsm.sv
// Mode controller for the alarm clock display path: keypad entry, alarm/time loading, LCD source select.
module alarm_clock_fsm
    import alarm_clock_fsm_pkg::*;
#(
    parameter int         TIMEOUT_SEC = TIMEOUT_SEC_DFLT,
    parameter logic [3:0] NOKEY       = NOKEY_CODE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic       shift,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       show_a,
    output logic       show_new_time
);

    state_t state_q;
    state_t state_d;
    logic   shift_q;
    logic   load_new_a_q;
    logic   load_new_c_q;
    logic   show_a_q;
    logic   show_new_time_q;
    logic   timer_clear_s;
    logic   timer_enable_s;
    logic   timeout_s;
    logic   pressed_s;

    assign pressed_s      = key_pressed(key, NOKEY);
    assign timer_clear_s  = (state_q == KEY_STORED);
    assign timer_enable_s = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);

    key_timeout_timer #(
        .TIMEOUT_SEC (TIMEOUT_SEC)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (timer_clear_s),
        .enable     (timer_enable_s),
        .one_second (one_second),
        .timeout    (timeout_s)
    );

    // Next-state decode; branch order within each state is the event priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SHOW_TIME: begin
                if (pressed_s)         state_d = KEY_STORED;
                else if (alarm_button) state_d = SHOW_ALARM;
                else                   state_d = SHOW_TIME;
            end
            KEY_STORED:       state_d = KEY_WAITED;
            KEY_WAITED: begin
                if (!pressed_s)        state_d = KEY_ENTRY;
                else if (timeout_s)    state_d = SHOW_TIME;
                else                   state_d = KEY_WAITED;
            end
            KEY_ENTRY: begin
                if (pressed_s)         state_d = KEY_STORED;
                else if (alarm_button) state_d = SET_ALARM_TIME;
                else if (time_button)  state_d = SET_CURRENT_TIME;
                else if (timeout_s)    state_d = SHOW_TIME;
                else                   state_d = KEY_ENTRY;
            end
            SHOW_ALARM: begin
                if (!alarm_button)     state_d = SHOW_TIME;
                else                   state_d = SHOW_ALARM;
            end
            SET_ALARM_TIME:   state_d = SHOW_TIME;
            SET_CURRENT_TIME: state_d = SHOW_TIME;
            default:          state_d = SHOW_TIME;
        endcase
    end

    // State register; outputs are decoded from the next state so they track state_q exactly.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= SHOW_TIME;
            shift_q         <= 1'b0;
            load_new_a_q    <= 1'b0;
            load_new_c_q    <= 1'b0;
            show_a_q        <= 1'b0;
            show_new_time_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            shift_q         <= (state_d == KEY_STORED);
            load_new_a_q    <= (state_d == SET_ALARM_TIME);
            load_new_c_q    <= (state_d == SET_CURRENT_TIME);
            show_a_q        <= (state_d == SHOW_ALARM);
            show_new_time_q <= (state_d == KEY_STORED) || (state_d == KEY_WAITED) ||
                               (state_d == KEY_ENTRY);
        end
    end

    assign shift         = shift_q;
    assign load_new_a    = load_new_a_q;
    assign load_new_c    = load_new_c_q;
    assign show_a        = show_a_q;
    assign show_new_time = show_new_time_q;

endmodule

// File: tb/tb_alarm_clock_fsm.sv
// Directed scoreboard bench for alarm_clock_fsm: a behavioural model queues expected outputs per cycle.
module tb_alarm_clock_fsm;

    localparam int         TO = 10;
    localparam logic [3:0] NK = 4'hA;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       one_second = 1'b0;
    logic [3:0] key = 4'hA;
    logic       alarm_button = 1'b0;
    logic       time_button = 1'b0;
    logic       shift, load_new_a, load_new_c, show_a, show_new_time;

    int         n_tests = 0;
    int         n_fail = 0;
    int         m_state = 0;
    int         m_timer = 0;
    int         shift_cnt = 0, loada_cnt = 0, loadc_cnt = 0, showa_cnt = 0;
    logic [4:0] last_obs = 5'd0;
    logic [4:0] exp_q[$];
    string      cur_tag = "init";

    alarm_clock_fsm dut (
        .clock         (clock),
        .reset         (reset),
        .one_second    (one_second),
        .key           (key),
        .alarm_button  (alarm_button),
        .time_button   (time_button),
        .shift         (shift),
        .load_new_a    (load_new_a),
        .load_new_c    (load_new_c),
        .show_a        (show_a),
        .show_new_time (show_new_time)
    );

    always #5 clock = ~clock;

    // Output bits: {shift, load_new_a, load_new_c, show_a, show_new_time}
    function automatic logic [4:0] decode(input int s);
        case (s)
            1:       return 5'b10001;
            2, 3:    return 5'b00001;
            4:       return 5'b00010;
            5:       return 5'b01000;
            6:       return 5'b00100;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s observed=%0h expected=%0h", cur_tag, tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] dut_out();
        return {shift, load_new_a, load_new_c, show_a, show_new_time};
    endfunction

    task automatic step(input logic [3:0] k, input logic ab, input logic tbn, input logic os);
        int   ns;
        logic en, to, pr;
        logic [4:0] e;
        key = k; alarm_button = ab; time_button = tbn; one_second = os;
        en = (m_state == 2) || (m_state == 3);
        to = en && os && (m_timer == TO - 1);
        pr = (k != NK);
        ns = m_state;
        case (m_state)
            0: begin if (pr) ns = 1; else if (ab) ns = 4; end
            1: ns = 2;
            2: begin if (!pr) ns = 3; else if (to) ns = 0; end
            3: begin
                if (pr) ns = 1; else if (ab) ns = 5;
                else if (tbn) ns = 6; else if (to) ns = 0;
            end
            4: begin if (!ab) ns = 0; end
            default: ns = 0;
        endcase
        if (m_state == 1) m_timer = 0;
        else if (en && os && m_timer < TO) m_timer++;
        m_state = ns;
        exp_q.push_back(decode(ns));
        @(posedge clock);
        #1;
        last_obs = dut_out();
        e = exp_q.pop_front();
        check("outputs", 32'(last_obs), 32'(e));
        shift_cnt += int'(last_obs[4]);
        loada_cnt += int'(last_obs[3]);
        loadc_cnt += int'(last_obs[2]);
        showa_cnt += int'(last_obs[1]);
    endtask

    task automatic clr_counts();
        shift_cnt = 0; loada_cnt = 0; loadc_cnt = 0; showa_cnt = 0;
    endtask

    initial begin
        // Reset state
        cur_tag = "reset";
        #1;
        check("reset_outputs", 32'(dut_out()), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        check("reset_hold", 32'(dut_out()), 32'd0);
        reset = 1'b1;

        // 1: reset mid-entry with a key held
        cur_tag = "t1_reset_mid_entry";
        step(4'h1, 1'b0, 1'b0, 1'b0);
        step(NK, 1'b0, 1'b0, 1'b0);
        step(NK, 1'b0, 1'b0, 1'b0);
        key = 4'h3;
        reset = 1'b0;
        #1;
        check("async_clear", 32'(dut_out()), 32'd0);
        m_state = 0; m_timer = 0;
        repeat (2) @(posedge clock);
        #1;
        check("held_in_reset", 32'(dut_out()), 32'd0);
        key = NK;
        @(posedge clock);
        #1;
        reset = 1'b1;
        clr_counts();
        repeat (3) step(NK, 1'b0, 1'b0, 1'b0);
        check("no_shift_after", 32'(shift_cnt), 32'd0);

        // time_button ignored in SHOW_TIME
        cur_tag = "time_btn_idle";
        step(NK, 1'b0, 1'b1, 1'b0);
        check("ignored", 32'(last_obs), 32'd0);

        // 2: four digits then alarm_button
        cur_tag = "t2_four_keys";
        clr_counts();
        for (int d = 1; d <= 4; d++) begin
            repeat (5) step(4'(d), 1'b0, 1'b0, 1'b0);
            repeat (2) step(NK, 1'b0, 1'b0, 1'b0);
        end
        step(NK, 1'b1, 1'b0, 1'b0);
        step(NK, 1'b0, 1'b0, 1'b0);
        check("shift_count", 32'(shift_cnt), 32'd4);
        check("load_a_count", 32'(loada_cnt), 32'd1);
        check("load_c_count", 32'(loadc_cnt), 32'd0);
        check("back_show_time", 32'(last_obs), 32'd0);

        // 3: alarm_button beats time_button
        cur_tag = "t3_both_buttons";
        clr_counts();
        step(4'h5, 1'b0, 1'b0, 1'b0);
        step(NK, 1'b0, 1'b0, 1'b0);
        step(NK, 1'b0, 1'b0, 1'b0);
        step(NK, 1'b1, 1'b1, 1'b0);
        check("load_a_only", 32'(last_obs), 32'h08);
        step(NK, 1'b0, 1'b0, 1'b0);
        check("load_a_count", 32'(loada_cnt), 32'd1);
        check("load_c_count", 32'(loadc_cnt), 32'd0);

        // 4: timeout, with a key on the 9th pulse restarting the count
        cur_tag = "t4_timeout";
        clr_counts();
        step(4'h7, 1'b0, 1'b0, 1'b0);
        step(NK, 1'b0, 1'b0, 1'b0);
        step(NK, 1'b0, 1'b0, 1'b0);
        for (int p = 1; p <= 8; p++) begin
            step(NK, 1'b0, 1'b0, 1'b1);
            step(NK, 1'b0, 1'b0, 1'b0);
        end
        step(4'h5, 1'b0, 1'b0, 1'b1);
        check("restart_shift", 32'(last_obs), 32'h11);
        step(NK, 1'b0, 1'b0, 1'b0);
        step(NK, 1'b0, 1'b0, 1'b0);
        for (int p = 1; p <= 9; p++) begin
            step(NK, 1'b0, 1'b0, 1'b1);
            step(NK, 1'b0, 1'b0, 1'b0);
        end
        check("still_entry_after_9", 32'(last_obs), 32'h01);
        step(NK, 1'b0, 1'b0, 1'b1);
        check("show_time_after_10", 32'(last_obs), 32'd0);
        check("no_loads", 32'(loada_cnt + loadc_cnt), 32'd0);

        // 6: key on the final timeout pulse wins
        cur_tag = "t6_key_beats_timeout";
        clr_counts();
        step(4'h8, 1'b0, 1'b0, 1'b0);
        step(NK, 1'b0, 1'b0, 1'b0);
        step(NK, 1'b0, 1'b0, 1'b0);
        for (int p = 1; p <= 9; p++) begin
            step(NK, 1'b0, 1'b0, 1'b1);
            step(NK, 1'b0, 1'b0, 1'b0);
        end
        step(4'h2, 1'b0, 1'b0, 1'b1);
        check("shift_wins", 32'(last_obs), 32'h11);
        step(NK, 1'b0, 1'b0, 1'b0);
        step(NK, 1'b0, 1'b0, 1'b0);
        step(NK, 1'b0, 1'b1, 1'b0);
        check("load_c", 32'(last_obs), 32'h04);
        step(NK, 1'b0, 1'b0, 1'b0);
        check("load_c_count", 32'(loadc_cnt), 32'd1);

        // 5: alarm display while button held
        cur_tag = "t5_show_alarm";
        clr_counts();
        repeat (20) step(NK, 1'b1, 1'b0, 1'b0);
        check("show_a_cycles", 32'(showa_cnt), 32'd20);
        step(NK, 1'b0, 1'b0, 1'b0);
        check("show_a_drops", 32'(last_obs), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
